// File: rtl/rom_model_pl.sv
// rtl/rom_model_pl.sv - pipelined, in-system-programmable ROM model behind an active-low chip interface
module rom_model_pl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DATA_DEPTH = 21,
    parameter int RD_LATENCY = 2,
    parameter int INIT_BASE  = 'h10,
    parameter int INIT_STEP  = 3,
    parameter int FILL_VAL   = 'hEE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              CE_bar,
    input  logic              OE_bar,
    input  logic              WE_bar,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_out_vld,
    output logic              rd_err,
    output logic              wr_err,
    output logic [15:0]       rd_count
);

    // Address extended by one bit so DATA_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DATA_DEPTH);

    logic [ADDR_W:0]   addr_ext;
    logic              rd_issue;
    logic              wr_issue;
    logic              in_range;
    logic [DATA_W-1:0] rd_word_d;
    logic              wr_err_d;
    logic              wr_err_q;
    logic [15:0]       rd_count_d;
    logic [15:0]       rd_count_q;

    logic [DATA_W-1:0] mem_q  [DATA_DEPTH];
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] err_q;
    logic [DATA_W-1:0]     data_q [RD_LATENCY];

    assign addr_ext = {1'b0, rd_addr};
    assign rd_issue = !CE_bar && !OE_bar && WE_bar;
    assign wr_issue = !CE_bar && !WE_bar;
    assign in_range = addr_ext < DEPTH_EXT;

    // Word presented at the issue edge: the stored value, or the fill value when out of range.
    always_comb begin
        rd_word_d = DATA_W'(FILL_VAL);
        for (int i = 0; i < DATA_DEPTH; i++) begin
            if (addr_ext == (ADDR_W + 1)'(i)) begin
                rd_word_d = mem_q[i];
            end
        end
    end

    // Next-state for the write-error pulse and the saturating read counter.
    always_comb begin
        wr_err_d   = wr_issue && !in_range;
        rd_count_d = rd_count_q;
        if (rd_issue && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    // Memory array: reset loads the linear pattern, in-range program writes update one word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                mem_q[i] <= DATA_W'(INIT_BASE + i * INIT_STEP);
            end
        end else if (wr_issue) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                if (addr_ext == (ADDR_W + 1)'(i)) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    // Read pipeline: stage 0 captures at issue, last stage is the output register.
    // Data and err are forced to zero for non-issue slots so idle outputs read as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= rd_issue;
            err_q[0]  <= rd_issue && !in_range;
            data_q[0] <= rd_issue ? rd_word_d : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Status registers: write-error pulse and read counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_q   <= 1'b0;
            rd_count_q <= '0;
        end else begin
            wr_err_q   <= wr_err_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_data         = data_q[RD_LATENCY-1];
    assign rd_data_out_vld = vld_q[RD_LATENCY-1];
    assign rd_err          = err_q[RD_LATENCY-1];
    assign wr_err          = wr_err_q;
    assign rd_count        = rd_count_q;

    // Parameter sanity and X watch on the control pins while the chip is selected.
    always @(posedge clk) begin
        assert (RD_LATENCY >= 1 && RD_LATENCY <= 8)
            else $error("rom_model_pl: RD_LATENCY %0d outside 1..8", RD_LATENCY);
        assert (DATA_DEPTH >= 1 && DATA_DEPTH <= (1 << ADDR_W))
            else $error("rom_model_pl: DATA_DEPTH %0d exceeds address space", DATA_DEPTH);
        if (CE_bar === 1'b0 && $isunknown({OE_bar, WE_bar})) begin
            $warning("rom_model_pl: unknown OE_bar/WE_bar while CE_bar is low");
        end
    end

endmodule

// File: tb/tb_rom_model_pl.sv
// tb/tb_rom_model_pl.sv - randomized and directed bench for rom_model_pl at latencies 1, 2 and 8
module tb_rom_model_pl;

    localparam int DEPTH = 21;
    localparam int BASE  = 'h10;
    localparam int STEP  = 3;
    localparam int FILL  = 'hEE;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce_bar, oe_bar, we_bar;
    logic [7:0] addr, wdata;

    logic [7:0]  dout [3];
    logic        vld  [3];
    logic        rerr [3];
    logic        werr [3];
    logic [15:0] cnt  [3];

    always #5 clk = ~clk;

    rom_model_pl #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .CE_bar(ce_bar), .OE_bar(oe_bar), .WE_bar(we_bar),
        .rd_addr(addr), .wr_data(wdata), .rd_data(dout[0]), .rd_data_out_vld(vld[0]),
        .rd_err(rerr[0]), .wr_err(werr[0]), .rd_count(cnt[0]));

    rom_model_pl u_l2 (
        .clk(clk), .reset_n(reset_n), .CE_bar(ce_bar), .OE_bar(oe_bar), .WE_bar(we_bar),
        .rd_addr(addr), .wr_data(wdata), .rd_data(dout[1]), .rd_data_out_vld(vld[1]),
        .rd_err(rerr[1]), .wr_err(werr[1]), .rd_count(cnt[1]));

    rom_model_pl #(.RD_LATENCY(8)) u_l8 (
        .clk(clk), .reset_n(reset_n), .CE_bar(ce_bar), .OE_bar(oe_bar), .WE_bar(we_bar),
        .rd_addr(addr), .wr_data(wdata), .rd_data(dout[2]), .rd_data_out_vld(vld[2]),
        .rd_err(rerr[2]), .wr_err(werr[2]), .rd_count(cnt[2]));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: memory contents, counters, and per-edge read results keyed by edge number.
    logic [7:0] mem_m [DEPTH];
    int         cnt_m;
    bit         werr_m;
    bit         hv [int];
    logic [7:0] hd [int];
    bit         he [int];

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'((BASE + i * STEP) % 256);
        cnt_m  = 0;
        werr_m = 0;
        hv.delete();
        hd.delete();
        he.delete();
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // A read issued at edge n appears at a latency-L output after edge n+L-1.
    task automatic compare_outputs();
        for (int k = 0; k < 3; k++) begin
            int         lat = lat_of(k);
            int         idx = cyc - lat + 1;
            bit         ev  = hv.exists(idx);
            logic [7:0] ed  = ev ? hd[idx] : 8'h00;
            bit         ee  = ev ? he[idx] : 1'b0;
            check($sformatf("vld_L%0d", lat),    {31'b0, vld[k]},  {31'b0, ev});
            check($sformatf("data_L%0d", lat),   {24'b0, dout[k]}, {24'b0, ed});
            check($sformatf("rderr_L%0d", lat),  {31'b0, rerr[k]}, {31'b0, ee});
            check($sformatf("wrerr_L%0d", lat),  {31'b0, werr[k]}, {31'b0, werr_m});
            check($sformatf("count_L%0d", lat),  {16'b0, cnt[k]},  cnt_m);
        end
    endtask

    task automatic cycle(input bit ce, input bit oe, input bit we, input logic [7:0] a, input logic [7:0] d);
        ce_bar = ce; oe_bar = oe; we_bar = we; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cyc++;
        werr_m = 0;
        if (!ce && !oe && we) begin
            hv[cyc] = 1'b1;
            hd[cyc] = (a < DEPTH) ? mem_m[a] : 8'(FILL);
            he[cyc] = (a >= DEPTH);
            if (cnt_m < 65535) cnt_m++;
        end else if (!ce && !we) begin
            if (a < DEPTH) mem_m[a] = d;
            else           werr_m = 1'b1;
        end
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a);                     cycle(1'b0, 1'b0, 1'b1, a, 8'h00); endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d); cycle(1'b0, 1'b1, 1'b0, a, d);     endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        ce_bar = 1'b1; oe_bar = 1'b1; we_bar = 1'b1;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check("rst_vld",   {31'b0, vld[k]},  32'd0);
            check("rst_data",  {24'b0, dout[k]}, 32'd0);
            check("rst_rderr", {31'b0, rerr[k]}, 32'd0);
            check("rst_wrerr", {31'b0, werr[k]}, 32'd0);
            check("rst_count", {16'b0, cnt[k]},  32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] cnt_before;
        ce_bar = 1'b1; oe_bar = 1'b1; we_bar = 1'b1; addr = '0; wdata = '0;
        reset_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Single read of addr 5 seen at +1, +2 and +8.
        rd(8'd5);
        check("tp_rd5_L1", {24'b0, dout[0]}, 32'h1F);
        idle(1);
        check("tp_rd5_L2", {24'b0, dout[1]}, 32'h1F);
        check("tp_cnt1",   {16'b0, cnt[1]},  32'd1);
        idle(6);
        check("tp_rd5_L8_vld", {31'b0, vld[2]}, 32'd1);
        check("tp_rd5_L8", {24'b0, dout[2]}, 32'h1F);
        idle(2);

        // Back-to-back reads.
        rd(8'd0); rd(8'd1);
        check("tp_b2b0", {24'b0, dout[1]}, 32'h10);
        rd(8'd2);
        check("tp_b2b1", {24'b0, dout[1]}, 32'h13);
        idle(1);
        check("tp_b2b2", {24'b0, dout[1]}, 32'h16);
        idle(8);

        // Out-of-range reads at the depth boundary and the top of the address space.
        rd(8'd21); rd(8'd255);
        check("tp_oor21_data", {24'b0, dout[1]}, 32'hEE);
        check("tp_oor21_err",  {31'b0, rerr[1]}, 32'd1);
        idle(1);
        check("tp_oor255_err", {31'b0, rerr[1]}, 32'd1);
        idle(8);
        rd(8'd20); idle(1);
        check("tp_last_word", {24'b0, dout[1]}, 32'h4C);
        idle(8);

        // Program writes, out-of-range write, reset restores pattern.
        wr(8'd4, 8'hA5); rd(8'd4); idle(1);
        check("tp_wr_a5", {24'b0, dout[1]}, 32'hA5);
        idle(8);
        wr(8'd30, 8'h00);
        check("tp_wrerr_pulse", {31'b0, werr[1]}, 32'd1);
        idle(1);
        check("tp_wrerr_clear", {31'b0, werr[1]}, 32'd0);
        do_reset();
        rd(8'd4); idle(1);
        check("tp_rst_pattern", {24'b0, dout[1]}, 32'h1C);
        idle(8);

        // Read-before-write ordering.
        rd(8'd7); wr(8'd7, 8'h5A);
        check("tp_old_data", {24'b0, dout[1]}, 32'h25);
        rd(8'd7); idle(1);
        check("tp_new_data", {24'b0, dout[1]}, 32'h5A);
        idle(8);

        // Reset with reads in flight.
        rd(8'd1); rd(8'd2); rd(8'd3);
        do_reset();
        idle(10);

        // Chip not selected: no read even with OE_bar low.
        cnt_before = cnt[1];
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'd9, 8'h00);
        idle(8);
        check("tp_ce_high_cnt", {16'b0, cnt[1]}, {16'b0, cnt_before});

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit         c, o, w;
            logic [7:0] a;
            c = ($urandom_range(0, 4) == 0);
            o = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 25));
            if ($urandom_range(0, 149) == 0) do_reset();
            else cycle(c, o, w, a, 8'($urandom));
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
